// File: rtl/music_box_pkg.sv
// rtl/music_box_pkg.sv - shared constants, types and helpers for the key tone generator
package music_box_pkg;

  localparam int NUM_KEYS = 6;
  localparam int SAMPLE_W = 16;

  // Element 0 is C4; clocks per half-cycle at 50 MHz.
  localparam logic [NUM_KEYS-1:0][31:0] DEFAULT_HALF_PERIOD = {
    32'd56818, 32'd63776, 32'd71586, 32'd75843, 32'd85131, 32'd95556
  };

  typedef logic signed [SAMPLE_W-1:0]      sample_t;
  typedef logic [NUM_KEYS-1:0]             keys_t;
  typedef logic [$clog2(NUM_KEYS+1)-1:0]   count_t;

  function automatic count_t popcount(keys_t k);
    count_t n;
    n = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      n = n + count_t'(k[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/music_key_tone_generator_if.sv
// rtl/music_key_tone_generator_if.sv - key vector in, mixed PCM sample stream out
interface music_key_tone_generator_if;
  import music_box_pkg::*;

  keys_t   keyPressed;
  sample_t sample_out;
  logic    sample_valid;
  count_t  active_count;

  modport master (
    output keyPressed,
    input  sample_out,
    input  sample_valid,
    input  active_count
  );

  modport slave (
    input  keyPressed,
    output sample_out,
    output sample_valid,
    output active_count
  );

endinterface

// File: rtl/tone_voice.sv
// rtl/tone_voice.sv - one fixed-pitch square-wave voice, re-armed high whenever disabled
module tone_voice #(
  parameter int HALF_PERIOD = 16,
  parameter int CNT_W       = 17
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic level_o
);

  if (HALF_PERIOD < 1 || HALF_PERIOD > (2 ** CNT_W)) begin : g_bad_half_period
    $fatal(1, "tone_voice: HALF_PERIOD does not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF_PERIOD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;

  always_comb begin
    cnt_d   = cnt_q + CNT_W'(1);
    level_d = level_q;
    if (!en_i) begin
      cnt_d   = '0;
      level_d = 1'b1;
    end else if (cnt_q == LAST) begin
      cnt_d   = '0;
      level_d = ~level_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      level_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/music_key_tone_generator.sv
// rtl/music_key_tone_generator.sv - per-key square voices mixed into a strobed signed sample stream
module music_key_tone_generator
  import music_box_pkg::*;
#(
  parameter int                          CNT_W       = 17,
  parameter logic [NUM_KEYS-1:0][31:0]   HALF_PERIOD = DEFAULT_HALF_PERIOD,
  parameter int                          SAMPLE_DIV  = 1042,
  parameter int                          AMPLITUDE   = 4096
) (
  input  logic                      clock_50Mhz,
  input  logic                      reset,
  music_key_tone_generator_if.slave io
);

  if (NUM_KEYS * AMPLITUDE > 32767) begin : g_amp_too_big
    $fatal(1, "music_key_tone_generator: NUM_KEYS*AMPLITUDE overflows the sample");
  end

  localparam int      DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam sample_t AMP   = sample_t'(AMPLITUDE);

  keys_t            key_q;
  keys_t            level;
  logic [DIV_W-1:0] div_q, div_d;
  logic             strobe;
  sample_t          mix;
  sample_t          sample_q, sample_d;
  logic             valid_q;
  count_t           count_q;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_voice
    tone_voice #(
      .HALF_PERIOD (HALF_PERIOD[g]),
      .CNT_W       (CNT_W)
    ) u_voice (
      .clk_i   (clock_50Mhz),
      .rst_i   (reset),
      .en_i    (key_q[g]),
      .level_o (level[g])
    );
  end

  always_comb begin
    strobe = (div_q == DIV_W'(SAMPLE_DIV - 1));
    div_d  = strobe ? '0 : div_q + DIV_W'(1);
  end

  // Uses the levels present in the strobe cycle, so a voice toggling on that edge counts pre-toggle.
  always_comb begin
    mix = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (key_q[i]) begin
        mix = level[i] ? (mix + AMP) : (mix - AMP);
      end
    end
    sample_d = strobe ? mix : sample_q;
  end

  always_ff @(posedge clock_50Mhz) begin
    if (reset) begin
      key_q    <= '0;
      div_q    <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      key_q    <= io.keyPressed;
      div_q    <= div_d;
      sample_q <= sample_d;
      valid_q  <= strobe;
      count_q  <= popcount(key_q);
    end
  end

  assign io.sample_out   = sample_q;
  assign io.sample_valid = valid_q;
  assign io.active_count = count_q;

endmodule

// File: tb/tb_music_key_tone_generator.sv
// tb/tb_music_key_tone_generator.sv - scoreboard bench for the key tone generator
module tb_music_key_tone_generator;
  import music_box_pkg::*;

  localparam int AMP  = 1000;
  localparam int SDIV = 5;
  localparam logic [NUM_KEYS-1:0][31:0] HP_A = {6{32'd16}};
  localparam logic [NUM_KEYS-1:0][31:0] HP_B = {32'd16, 32'd16, 32'd16, 32'd16, 32'd8, 32'd16};

  typedef struct {
    int sample;
    int active;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  music_key_tone_generator_if if_a ();
  music_key_tone_generator_if if_b ();

  music_key_tone_generator #(
    .CNT_W(17), .HALF_PERIOD(HP_A), .SAMPLE_DIV(SDIV), .AMPLITUDE(AMP)
  ) dut_a (
    .clock_50Mhz (clk),
    .reset       (reset),
    .io          (if_a)
  );

  music_key_tone_generator #(
    .CNT_W(17), .HALF_PERIOD(HP_B), .SAMPLE_DIV(SDIV), .AMPLITUDE(AMP)
  ) dut_b (
    .clock_50Mhz (clk),
    .reset       (reset),
    .io          (if_b)
  );

  always #5 clk = ~clk;

  exp_t  q_a[$];
  exp_t  q_b[$];
  exp_t  ea, eb;
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc;
  keys_t kq;
  int    start[NUM_KEYS];
  bit    use_tbl;
  int    tbl[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Closed form: a voice pressed at edge start shows high for j/hp even, j edges later.
  function automatic int expect_sample(keys_t prior, int c, logic [NUM_KEYS-1:0][31:0] hp);
    int s;
    int j;
    s = 0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (prior[i]) begin
        j = c - 1 - start[i];
        s += (((j / int'(hp[i])) % 2) == 0) ? AMP : -AMP;
      end
    end
    return s;
  endfunction

  task automatic step(input keys_t keys, input bit rst);
    keys_t prior;
    exp_t  e;
    if_a.keyPressed = keys;
    if_b.keyPressed = keys;
    reset = rst;
    @(posedge clk);
    #1;
    if (rst) begin
      cyc = -1;
      kq  = '0;
    end else begin
      cyc++;
      prior = kq;
      if (cyc % SDIV == SDIV - 1) begin
        e.active = $countones(prior);
        e.sample = expect_sample(prior, cyc, HP_B);
        q_b.push_back(e);
        if (use_tbl && tbl.size() > 0) e.sample = tbl.pop_front();
        else                           e.sample = expect_sample(prior, cyc, HP_A);
        q_a.push_back(e);
      end
      kq = keys;
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (kq[i] && !prior[i]) start[i] = cyc;
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_a_sample"}, int'($signed(if_a.sample_out)), 0);
    check({tag, "_a_active"}, int'(if_a.active_count), 0);
    check({tag, "_a_valid"},  int'(if_a.sample_valid), 0);
    check({tag, "_b_sample"}, int'($signed(if_b.sample_out)), 0);
    check({tag, "_b_active"}, int'(if_b.active_count), 0);
  endtask

  task automatic reset_seq(input keys_t keys, input string tag);
    for (int i = 0; i < 3; i++) step(keys, 1'b1);
    check_reset_state(tag);
  endtask

  always @(negedge clk) begin
    if (if_a.sample_valid === 1'b1) begin
      if (q_a.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL a_unexpected_strobe: got sample_valid=1, expected 0");
      end else begin
        ea = q_a.pop_front();
        check("a_sample", int'($signed(if_a.sample_out)), ea.sample);
        check("a_active", int'(if_a.active_count), ea.active);
      end
    end
  end

  always @(negedge clk) begin
    if (if_b.sample_valid === 1'b1) begin
      if (q_b.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL b_unexpected_strobe: got sample_valid=1, expected 0");
      end else begin
        eb = q_b.pop_front();
        check("b_sample", int'($signed(if_b.sample_out)), eb.sample);
        check("b_active", int'(if_b.active_count), eb.active);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end within 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    use_tbl = 1'b0;
    cyc     = -1;
    kq      = '0;
    for (int i = 0; i < NUM_KEYS; i++) start[i] = 0;

    // Idle: only zero samples, strobe every SDIV clocks.
    reset_seq(6'h00, "t1_reset");
    for (int i = 0; i < 50; i++) step(6'h00, 1'b0);

    // Single voice, hand-computed strobe values.
    reset_seq(6'h01, "t2_reset");
    tbl = '{1000, 1000, 1000, -1000, -1000, -1000, 1000, 1000, 1000, -1000};
    use_tbl = 1'b1;
    step(6'h01, 1'b0);
    check("t2_active_c0", int'(if_a.active_count), 0);
    step(6'h01, 1'b0);
    check("t2_active_c1", int'(if_a.active_count), 1);
    for (int i = 2; i < 50; i++) step(6'h01, 1'b0);
    use_tbl = 1'b0;

    // All six voices in phase.
    reset_seq(6'h3f, "t3_reset");
    tbl = '{6000, 6000, 6000, -6000, -6000, -6000, 6000, 6000, 6000, -6000};
    use_tbl = 1'b1;
    for (int i = 0; i < 50; i++) step(6'h3f, 1'b0);
    use_tbl = 1'b0;

    // Two voices; dut_b runs voice 1 at half the period.
    reset_seq(6'h03, "t4_reset");
    for (int i = 0; i < 60; i++) step(6'h03, 1'b0);

    // Release while low, re-press 7 clocks later.
    reset_seq(6'h01, "t5_reset");
    for (int i = 0; i < 20; i++) step(6'h01, 1'b0);
    for (int i = 0; i < 7; i++)  step(6'h00, 1'b0);
    for (int i = 0; i < 30; i++) step(6'h01, 1'b0);

    // One-cycle reset mid-note with all keys held.
    reset_seq(6'h3f, "t6_reset");
    for (int i = 0; i < 21; i++) step(6'h3f, 1'b0);
    step(6'h3f, 1'b1);
    check_reset_state("t6_midnote");
    for (int i = 0; i < 40; i++) step(6'h3f, 1'b0);

    @(posedge clk);
    #1;
    check("a_queue_drained", q_a.size(), 0);
    check("b_queue_drained", q_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
